// File: rtl/int_isq_dispatch.sv
// -----------------------------------------------------------------------------
// int_isq_dispatch
//   Producer side of the integer issue-queue enqueue interface. Renamed uops
//   from dispatch land in a 2-entry in-order skid buffer (slot 0 is the oldest)
//   and are presented to int_isq on enq_*. Buffered condition bits are kept
//   current with wakeup broadcasts, and buffered or incoming uops younger than a
//   flush point are discarded, so int_isq never receives a stale or flushed uop.
//
// Ports
//   clock, reset_n          clock and synchronous active-low reset
//   in_*                    uop offered by dispatch (valid/ready handshake)
//   enq_*                   uop presented to int_isq (valid/ready handshake)
//   update_condition_*      wakeup broadcast: robid match, mask, new bit values
//   flush_valid/_robid      kill every uop strictly younger than flush_robid
// -----------------------------------------------------------------------------
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4
`endif

module int_isq_dispatch #(
    parameter int DATA_WIDTH      = 248,
    parameter int CONDITION_WIDTH = 2,
    parameter int INDEX_WIDTH     = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [CONDITION_WIDTH-1:0] in_condition,
    input  logic [INDEX_WIDTH-1:0]     in_index,
    input  logic [`ROB_SIZE_LOG:0]     in_robid,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      enq_data,
    output logic [CONDITION_WIDTH-1:0] enq_condition,
    output logic [INDEX_WIDTH-1:0]     enq_index,
    output logic                       enq_valid,
    input  logic                       enq_ready,
    input  logic                       update_condition_valid,
    input  logic [`ROB_SIZE_LOG:0]     update_condition_robid,
    input  logic [CONDITION_WIDTH-1:0] update_condition_mask,
    input  logic [CONDITION_WIDTH-1:0] update_condition_in,
    input  logic                       flush_valid,
    input  logic [`ROB_SIZE_LOG:0]     flush_robid
);

    localparam int RW = `ROB_SIZE_LOG + 1;   // robid width including wrap bit
    localparam int IW = RW - 1;              // robid index part

    // Stored entries, slot 0 = head = oldest
    logic [DATA_WIDTH-1:0]      r_data  [2];
    logic [CONDITION_WIDTH-1:0] r_cond  [2];
    logic [INDEX_WIDTH-1:0]     r_index [2];
    logic [RW-1:0]              r_robid [2];
    logic [1:0]                 r_valid;

    // Wakeup-merged conditions and kill flags for stored and incoming uops
    logic [CONDITION_WIDTH-1:0] w_cond_m [2];
    logic [1:0]                 w_kill;
    logic [CONDITION_WIDTH-1:0] w_in_cond_m;
    logic                       w_in_kill;

    // Handshake decisions
    logic                       w_enq_valid;
    logic                       w_in_ready;
    logic                       w_pop;
    logic                       w_push;

    // State after kill and pop, before push
    logic [DATA_WIDTH-1:0]      w_s_data  [2];
    logic [CONDITION_WIDTH-1:0] w_s_cond  [2];
    logic [INDEX_WIDTH-1:0]     w_s_index [2];
    logic [RW-1:0]              w_s_robid [2];
    logic [1:0]                 w_s_valid;
    logic [1:0]                 w_keep;
    logic [1:0]                 w_wr;

    // a is strictly younger than f, wrap bit decides which index order applies
    function automatic logic f_younger(input logic [RW-1:0] a, input logic [RW-1:0] f);
        logic res;
        if (a[RW-1] == f[RW-1]) begin
            res = (a[IW-1:0] > f[IW-1:0]);
        end else begin
            res = (a[IW-1:0] < f[IW-1:0]);
        end
        return res;
    endfunction

    // Overwrite the masked condition bits when the wakeup targets this uop
    function automatic logic [CONDITION_WIDTH-1:0] f_merge(
        input logic [CONDITION_WIDTH-1:0] cond,
        input logic                       hit,
        input logic [CONDITION_WIDTH-1:0] mask,
        input logic [CONDITION_WIDTH-1:0] val
    );
        logic [CONDITION_WIDTH-1:0] res;
        if (hit) begin
            res = (cond & ~mask) | (val & mask);
        end else begin
            res = cond;
        end
        return res;
    endfunction

    // Wakeup merge and flush kill evaluation for every stored entry and the incoming uop
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_cond_m[i] = f_merge(r_cond[i],
                                  update_condition_valid && (r_robid[i] == update_condition_robid),
                                  update_condition_mask, update_condition_in);
            w_kill[i]   = flush_valid & f_younger(r_robid[i], flush_robid);
        end
        w_in_cond_m = f_merge(in_condition,
                              update_condition_valid && (in_robid == update_condition_robid),
                              update_condition_mask, update_condition_in);
        w_in_kill   = flush_valid & f_younger(in_robid, flush_robid);
    end

    // Handshakes; slot 1 occupied means the buffer is full because entries stay compacted
    always_comb begin
        w_in_ready  = reset_n & ~r_valid[1];
        w_enq_valid = reset_n & r_valid[0] & ~w_kill[0];
        w_pop       = w_enq_valid & enq_ready;
        w_push      = in_valid & w_in_ready & ~w_in_kill;
    end

    // Next state: wakeup, kill, pop (shift), then choose the slot the push lands in
    always_comb begin
        w_keep = r_valid & ~w_kill;
        w_s_data[1]  = r_data[1];
        w_s_cond[1]  = w_cond_m[1];
        w_s_index[1] = r_index[1];
        w_s_robid[1] = r_robid[1];
        if (w_pop) begin
            w_s_data[0]  = r_data[1];
            w_s_cond[0]  = w_cond_m[1];
            w_s_index[0] = r_index[1];
            w_s_robid[0] = r_robid[1];
            w_s_valid    = {1'b0, w_keep[1]};
        end else begin
            w_s_data[0]  = r_data[0];
            w_s_cond[0]  = w_cond_m[0];
            w_s_index[0] = r_index[0];
            w_s_robid[0] = r_robid[0];
            w_s_valid    = w_keep;
        end
        // Accept implies slot 1 was empty, so after kill/pop the first free slot is safe
        if (w_push) begin
            w_wr = w_s_valid[0] ? 2'b10 : 2'b01;
        end else begin
            w_wr = 2'b00;
        end
    end

    // Entry storage update with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i]  <= {DATA_WIDTH{1'b0}};
                r_cond[i]  <= {CONDITION_WIDTH{1'b0}};
                r_index[i] <= {INDEX_WIDTH{1'b0}};
                r_robid[i] <= {RW{1'b0}};
            end
            r_valid <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_wr[i]) begin
                    r_data[i]  <= in_data;
                    r_cond[i]  <= w_in_cond_m;
                    r_index[i] <= in_index;
                    r_robid[i] <= in_robid;
                    r_valid[i] <= 1'b1;
                end else begin
                    r_data[i]  <= w_s_data[i];
                    r_cond[i]  <= w_s_cond[i];
                    r_index[i] <= w_s_index[i];
                    r_robid[i] <= w_s_robid[i];
                    r_valid[i] <= w_s_valid[i];
                end
            end
        end
    end

    // Outputs: head fields, with condition bypassing the current-cycle wakeup
    always_comb begin
        in_ready  = w_in_ready;
        enq_valid = w_enq_valid;
        if (reset_n) begin
            enq_data      = r_data[0];
            enq_condition = w_cond_m[0];
            enq_index     = r_index[0];
        end else begin
            enq_data      = {DATA_WIDTH{1'b0}};
            enq_condition = {CONDITION_WIDTH{1'b0}};
            enq_index     = {INDEX_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_int_isq_dispatch.sv
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4
`endif

module tb_int_isq_dispatch;

    localparam int DW = 248;
    localparam int CW = 2;
    localparam int XW = 4;
    localparam int RW = `ROB_SIZE_LOG + 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_condition;
    logic [XW-1:0] in_index;
    logic [RW-1:0] in_robid;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] enq_data;
    logic [CW-1:0] enq_condition;
    logic [XW-1:0] enq_index;
    logic          enq_valid;
    logic          enq_ready;
    logic          update_condition_valid;
    logic [RW-1:0] update_condition_robid;
    logic [CW-1:0] update_condition_mask;
    logic [CW-1:0] update_condition_in;
    logic          flush_valid;
    logic [RW-1:0] flush_robid;

    int n_checks = 0;
    int n_errors = 0;
    bit was_acc;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] cond;
        logic [XW-1:0] index;
        logic [RW-1:0] robid;
    } uop_t;

    uop_t mq[$];   // reference contents, oldest first

    int_isq_dispatch dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .in_data                (in_data),
        .in_condition           (in_condition),
        .in_index               (in_index),
        .in_robid               (in_robid),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .enq_data               (enq_data),
        .enq_condition          (enq_condition),
        .enq_index              (enq_index),
        .enq_valid              (enq_valid),
        .enq_ready              (enq_ready),
        .update_condition_valid (update_condition_valid),
        .update_condition_robid (update_condition_robid),
        .update_condition_mask  (update_condition_mask),
        .update_condition_in    (update_condition_in),
        .flush_valid            (flush_valid),
        .flush_robid            (flush_robid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Age by modular distance: younger means 1..half-ring ahead of the flush point
    function automatic bit younger(input logic [RW-1:0] a, input logic [RW-1:0] f);
        logic [RW-1:0] d;
        d = a - f;
        return (d >= 1) && (d < (1 << (RW - 1)));
    endfunction

    function automatic bit killed(input logic [RW-1:0] r);
        return flush_valid && younger(r, flush_robid);
    endfunction

    function automatic logic [CW-1:0] woken(input logic [CW-1:0] c, input logic [RW-1:0] r);
        logic [CW-1:0] res;
        res = c;
        if (update_condition_valid && r == update_condition_robid) begin
            for (int b = 0; b < CW; b++)
                if (update_condition_mask[b]) res[b] = update_condition_in[b];
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d = (d << 32) | DW'($urandom());
        return d;
    endfunction

    // Inputs are set at a negedge; check outputs, advance the model, move to next negedge
    task automatic cycle();
        bit   exp_rdy, exp_vld;
        uop_t h, n;
        uop_t tmp[$];
        #1;
        exp_rdy = reset_n && (mq.size() < 2);
        exp_vld = 1'b0;
        if (reset_n && mq.size() > 0) exp_vld = !killed(mq[0].robid);
        check("in_ready", in_ready, exp_rdy);
        check("enq_valid", enq_valid, exp_vld);
        if (!reset_n) begin
            check("rst_data", enq_data, 0);
            check("rst_cond", enq_condition, 0);
            check("rst_index", enq_index, 0);
        end else if (exp_vld) begin
            h = mq[0];
            check("enq_data", enq_data, h.data);
            check("enq_cond", enq_condition, woken(h.cond, h.robid));
            check("enq_index", enq_index, h.index);
        end
        was_acc = 1'b0;
        if (!reset_n) begin
            mq.delete();
        end else begin
            foreach (mq[i]) mq[i].cond = woken(mq[i].cond, mq[i].robid);
            foreach (mq[i]) if (!killed(mq[i].robid)) tmp.push_back(mq[i]);
            mq = tmp;
            if (exp_vld && enq_ready) void'(mq.pop_front());
            if (in_valid && exp_rdy && !killed(in_robid)) begin
                n.data  = in_data;
                n.cond  = woken(in_condition, in_robid);
                n.index = in_index;
                n.robid = in_robid;
                mq.push_back(n);
                was_acc = 1'b1;
            end
        end
        @(negedge clock);
    endtask

    task automatic drive(input bit v, input logic [RW-1:0] rob, input logic [CW-1:0] c, input bit er);
        in_valid     = v;
        in_robid     = rob;
        in_condition = c;
        in_data      = rand_data();
        in_index     = XW'($urandom());
        enq_ready    = er;
        update_condition_valid = 1'b0;
        update_condition_robid = '0;
        update_condition_mask  = '0;
        update_condition_in    = '0;
        flush_valid  = 1'b0;
        flush_robid  = '0;
    endtask

    task automatic wake(input logic [RW-1:0] rob, input logic [CW-1:0] m, input logic [CW-1:0] v);
        update_condition_valid = 1'b1;
        update_condition_robid = rob;
        update_condition_mask  = m;
        update_condition_in    = v;
    endtask

    task automatic flush(input logic [RW-1:0] rob);
        flush_valid = 1'b1;
        flush_robid = rob;
    endtask

    initial begin
        logic [RW-1:0] rob;
        logic [RW-1:0] base;
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 2'b00, 1'b0);
        @(negedge clock);
        cycle(); cycle();
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 2'b00, 1'b1); cycle();

        // Back-to-back 3,4,5 with a ready consumer
        drive(1'b1, 5'd3, 2'b10, 1'b1); cycle();
        drive(1'b1, 5'd4, 2'b01, 1'b1); cycle();
        drive(1'b1, 5'd5, 2'b11, 1'b1); cycle();
        drive(1'b0, 5'd0, 2'b00, 1'b1); cycle(); cycle();

        // Stall with three offers, then release
        rob = 5'd6;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, rob, 2'b00, 1'b0); cycle();
            if (was_acc) rob = rob + 5'd1;
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, rob, 2'b00, 1'b1); cycle();
            if (was_acc) rob = rob + 5'd1;
            if (rob == 5'd9) break;
        end
        drive(1'b0, 5'd0, 2'b00, 1'b1); cycle(); cycle();

        // Wakeup on a stalled head, then on a uop accepted in the same cycle
        drive(1'b1, 5'd7, 2'b00, 1'b0); cycle();
        drive(1'b0, 5'd0, 2'b00, 1'b0); wake(5'd7, 2'b01, 2'b01);
        #1 check("t4_bypass", enq_condition, 2'b01);
        cycle();
        drive(1'b0, 5'd0, 2'b00, 1'b0); cycle();
        drive(1'b1, 5'd8, 2'b00, 1'b0); wake(5'd8, 2'b01, 2'b01); cycle();
        drive(1'b0, 5'd0, 2'b00, 1'b1); cycle(); cycle(); cycle();

        // Flush: equal id survives, older flush point kills both
        drive(1'b1, 5'd5, 2'b00, 1'b0); cycle();
        drive(1'b1, 5'd6, 2'b00, 1'b0); cycle();
        drive(1'b0, 5'd0, 2'b00, 1'b0); flush(5'd5); cycle();
        drive(1'b1, 5'd6, 2'b00, 1'b0); cycle();
        drive(1'b0, 5'd0, 2'b00, 1'b0); flush(5'd4);
        #1 check("t5_killed_head", enq_valid, 1'b0);
        cycle();
        drive(1'b0, 5'd0, 2'b00, 1'b1); cycle();

        // Wrap: {0,13} survives and {1,2} dies against flush point {0,14}
        drive(1'b1, 5'd13, 2'b00, 1'b0); cycle();
        drive(1'b1, 5'd18, 2'b00, 1'b0); cycle();
        drive(1'b1, 5'd19, 2'b00, 1'b0); flush(5'd14); cycle();
        drive(1'b0, 5'd0, 2'b00, 1'b1); cycle(); cycle();

        // Reset mid-stream with a full stalled buffer
        drive(1'b1, 5'd20, 2'b00, 1'b0); cycle();
        drive(1'b1, 5'd21, 2'b00, 1'b0); cycle();
        reset_n = 1'b0; drive(1'b0, 5'd0, 2'b00, 1'b0); cycle();
        reset_n = 1'b1; drive(1'b0, 5'd0, 2'b00, 1'b0); cycle();

        // Randomized traffic
        rob = 5'd22;
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 9) < 7, rob, CW'($urandom()), $urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 2))
                    0: base = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].robid : rob;
                    1: base = rob;
                    default: base = RW'($urandom());
                endcase
                wake(base, CW'($urandom()), CW'($urandom()));
            end
            if ($urandom_range(0, 19) == 0) begin
                base = (mq.size() > 0) ? mq[0].robid : rob;
                flush(base + RW'($urandom_range(0, 3)) - 5'd1);
            end
            cycle();
            if (reset_n && flush_valid) rob = flush_robid + 5'd1;
            else if (was_acc) rob = rob + 5'd1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
